// File: rtl/feedback_loop_multi_if.sv
// Sample/result bundle for the multi-channel feedback loop.
// The master drives samples and observes results; the slave is the loop itself.
interface feedback_loop_multi_if #(
  parameter int DATA_W = 8,
  parameter int CHAN_W = 2
);
  logic                     in_valid;
  logic [CHAN_W-1:0]        in_chan;
  logic signed [DATA_W-1:0] in_data;
  logic                     leak_en;
  logic                     clear;
  logic                     out_valid;
  logic [CHAN_W-1:0]        out_chan;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_sat;

  modport master (
    output in_valid, in_chan, in_data, leak_en, clear,
    input  out_valid, out_chan, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_chan, in_data, leak_en, clear,
    output out_valid, out_chan, out_data, out_sat
  );
endinterface

// File: rtl/feedback_loop_multi.sv
// Multi-channel saturating accumulate / leaky-integrate feedback loop.
// One signed state per channel, time-multiplexed over a single sample port;
// each accepted sample yields its saturated update one cycle later.
module feedback_loop_multi #(
  parameter int DATA_W     = 8,
  parameter int CHANNELS   = 4,
  parameter int CHAN_W     = 2,
  parameter int LEAK_SHIFT = 2
) (
  input  logic                  system1000,
  input  logic                  system1000_rstn,
  feedback_loop_multi_if.slave  bus
);

  // Two guard bits: |x| + |p| + |p>>>k| never exceeds 2^(DATA_W+1).
  localparam int SW = DATA_W + 2;
  localparam logic signed [SW-1:0] MAX_S = SW'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [SW-1:0] MIN_S = ~MAX_S;

  function automatic logic signed [DATA_W-1:0] sat_clip(input logic signed [SW-1:0] s);
    if (s > MAX_S)      return MAX_S[DATA_W-1:0];
    else if (s < MIN_S) return MIN_S[DATA_W-1:0];
    else                return s[DATA_W-1:0];
  endfunction

  function automatic logic sat_flag(input logic signed [SW-1:0] s);
    return (s > MAX_S) || (s < MIN_S);
  endfunction

  logic signed [DATA_W-1:0] y [CHANNELS];

  logic                     accept_p0;
  logic signed [DATA_W-1:0] y_sel_p0;
  logic signed [SW-1:0]     x_ext_p0;
  logic signed [SW-1:0]     p_ext_p0;
  logic signed [SW-1:0]     sum_p0;

  logic                     vld_p1;
  logic [CHAN_W-1:0]        chan_p1;
  logic signed [DATA_W-1:0] data_p1;
  logic                     sat_p1;

  // ---- stage p0: select channel state, form the wide update ----
  // Out-of-range channels match no state and are never accepted.
  always_comb begin
    y_sel_p0 = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (bus.in_chan == CHAN_W'(c)) y_sel_p0 = y[c];
    end
    accept_p0 = bus.in_valid && ({1'b0, bus.in_chan} < (CHAN_W + 1)'(CHANNELS));
    x_ext_p0  = {{2{bus.in_data[DATA_W-1]}}, bus.in_data};
    p_ext_p0  = bus.clear ? '0 : {{2{y_sel_p0[DATA_W-1]}}, y_sel_p0};
    if (bus.leak_en) sum_p0 = x_ext_p0 + p_ext_p0 - (p_ext_p0 >>> LEAK_SHIFT);
    else             sum_p0 = x_ext_p0 + p_ext_p0;
  end

  // ---- stage p1: state write-back; the sample's write beats a same-cycle clear ----
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      for (int c = 0; c < CHANNELS; c++) y[c] <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (accept_p0 && (bus.in_chan == CHAN_W'(c))) y[c] <= sat_clip(sum_p0);
        else if (bus.clear)                           y[c] <= '0;
      end
    end
  end

  // Result register: data/channel hold between pulses, sat only pulses with valid.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      vld_p1  <= 1'b0;
      sat_p1  <= 1'b0;
      chan_p1 <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= accept_p0;
      sat_p1 <= accept_p0 && sat_flag(sum_p0);
      if (accept_p0) begin
        chan_p1 <= bus.in_chan;
        data_p1 <= sat_clip(sum_p0);
      end
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.out_chan  = chan_p1;
  assign bus.out_data  = data_p1;
  assign bus.out_sat   = sat_p1;

endmodule

// File: tb/tb_feedback_loop_multi.sv
// Scoreboard bench for feedback_loop_multi: a 4-channel and a 3-channel instance.
module tb_feedback_loop_multi;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  always #5 clk = ~clk;

  feedback_loop_multi_if #(.DATA_W(8), .CHAN_W(2)) bus4 ();
  feedback_loop_multi_if #(.DATA_W(8), .CHAN_W(2)) bus3 ();

  feedback_loop_multi #(.DATA_W(8), .CHANNELS(4), .CHAN_W(2), .LEAK_SHIFT(2)) u_dut4 (
    .system1000      (clk),
    .system1000_rstn (rstn),
    .bus             (bus4)
  );

  feedback_loop_multi #(.DATA_W(8), .CHANNELS(3), .CHAN_W(2), .LEAK_SHIFT(2)) u_dut3 (
    .system1000      (clk),
    .system1000_rstn (rstn),
    .bus             (bus3)
  );

  typedef struct {
    int chan;
    int data;
    int sat;
  } exp_t;

  exp_t q4[$];
  exp_t q3[$];
  exp_t e4;
  exp_t e3;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int req);
    n_assert++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor for the 4-channel instance: pop and compare on every result pulse.
  always @(negedge clk) begin
    if (rstn && bus4.out_valid) begin
      if (q4.size() == 0) begin
        chk("dut4_unexpected_out", int'(bus4.out_data), -999);
      end else begin
        e4 = q4.pop_front();
        chk("dut4_out_chan", int'(bus4.out_chan), e4.chan);
        chk("dut4_out_data", int'(bus4.out_data), e4.data);
        chk("dut4_out_sat",  int'(bus4.out_sat),  e4.sat);
      end
    end
  end

  // Monitor for the 3-channel instance.
  always @(negedge clk) begin
    if (rstn && bus3.out_valid) begin
      if (q3.size() == 0) begin
        chk("dut3_unexpected_out", int'(bus3.out_data), -999);
      end else begin
        e3 = q3.pop_front();
        chk("dut3_out_chan", int'(bus3.out_chan), e3.chan);
        chk("dut3_out_data", int'(bus3.out_data), e3.data);
        chk("dut3_out_sat",  int'(bus3.out_sat),  e3.sat);
      end
    end
  end

  task automatic idle_inputs();
    bus4.in_valid = 1'b0; bus4.in_chan = '0; bus4.in_data = '0; bus4.leak_en = 1'b0; bus4.clear = 1'b0;
    bus3.in_valid = 1'b0; bus3.in_chan = '0; bus3.in_data = '0; bus3.leak_en = 1'b0; bus3.clear = 1'b0;
  endtask

  // Present one cycle of stimulus on instance sel (4 or 3) and queue its expected result.
  task automatic drive(input int sel, input int chan, input int data, input bit leak,
                       input bit clr, input bit vld, input bit exp_out,
                       input int exp_data, input int exp_sat);
    exp_t e;
    idle_inputs();
    e.chan = chan; e.data = exp_data; e.sat = exp_sat;
    if (sel == 4) begin
      bus4.in_valid = vld; bus4.in_chan = 2'(chan); bus4.in_data = 8'(data);
      bus4.leak_en = leak; bus4.clear = clr;
      if (exp_out) q4.push_back(e);
    end else begin
      bus3.in_valid = vld; bus3.in_chan = 2'(chan); bus3.in_data = 8'(data);
      bus3.leak_en = leak; bus3.clear = clr;
      if (exp_out) q3.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    idle_inputs();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_v4"}, int'(bus4.out_valid), 0);
    chk({tag, "_c4"}, int'(bus4.out_chan),  0);
    chk({tag, "_d4"}, int'(bus4.out_data),  0);
    chk({tag, "_s4"}, int'(bus4.out_sat),   0);
    chk({tag, "_v3"}, int'(bus3.out_valid), 0);
    chk({tag, "_c3"}, int'(bus3.out_chan),  0);
    chk({tag, "_d3"}, int'(bus3.out_data),  0);
    chk({tag, "_s3"}, int'(bus3.out_sat),   0);
  endtask

  initial begin
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("rst_initial");
    rstn = 1'b1;

    // Reset asserted mid-cycle while inputs toggle; ch0 state must also be wiped.
    drive(4, 0, 50, 0, 0, 1, 1, 50, 0);
    drive(3, 1, 33, 0, 0, 1, 1, 33, 0);
    #5;
    rstn = 1'b0;
    #1;
    chk_reset_outputs("rst_async");
    for (int i = 0; i < 3; i++) begin
      bus4.in_valid = 1'b1; bus4.in_chan = 2'(i); bus4.in_data = 8'($urandom_range(0, 255));
      bus3.in_valid = 1'b1; bus3.in_chan = 2'(i); bus3.in_data = 8'($urandom_range(0, 255));
      @(posedge clk);
      #1;
      chk_reset_outputs("rst_held");
    end
    idle_inputs();
    rstn = 1'b1;

    // Accumulate on ch0, first sample right after release.
    drive(4, 0, 10, 0, 0, 1, 1, 10, 0);
    drive(4, 0, 20, 0, 0, 1, 1, 30, 0);
    drive(4, 0, -5, 0, 0, 1, 1, 25, 0);
    idle_cycle();
    chk("hold_valid", int'(bus4.out_valid), 0);
    chk("hold_data",  int'(bus4.out_data),  25);
    chk("hold_chan",  int'(bus4.out_chan),  0);

    // Saturation on ch1, then clear without a sample, then negative saturation.
    drive(4, 1, 100,  0, 0, 1, 1, 100, 0);
    drive(4, 1, 100,  0, 0, 1, 1, 127, 1);
    drive(4, 1, -128, 0, 0, 1, 1, -1,  0);
    drive(4, 0, 0,    0, 1, 0, 0, 0,   0);
    drive(4, 1, -100, 0, 0, 1, 1, -100, 0);
    drive(4, 1, -100, 0, 0, 1, 1, -128, 1);

    // Leaky mode on ch2, including negative states and the -1 corner.
    drive(4, 2, 64,   1, 0, 1, 1, 64,  0);
    drive(4, 2, 0,    1, 0, 1, 1, 48,  0);
    drive(4, 2, 0,    1, 0, 1, 1, 36,  0);
    drive(4, 2, -100, 0, 0, 1, 1, -64, 0);
    drive(4, 2, 0,    1, 0, 1, 1, -48, 0);
    drive(4, 2, 47,   0, 0, 1, 1, -1,  0);
    drive(4, 2, 0,    1, 0, 1, 1, 0,   0);

    // Interleaved channels, then a sample coinciding with clear.
    drive(4, 3, 7, 0, 0, 1, 1, 7,  0);
    drive(4, 0, 1, 0, 0, 1, 1, 1,  0);
    drive(4, 3, 7, 0, 0, 1, 1, 14, 0);
    drive(4, 0, 1, 0, 0, 1, 1, 2,  0);
    drive(4, 0, 5, 0, 1, 1, 1, 5,  0);
    drive(4, 3, 1, 0, 0, 1, 1, 1,  0);
    drive(4, 0, 0, 0, 0, 1, 1, 5,  0);
    idle_cycle();

    // Three-channel instance: out-of-range channel is dropped.
    drive(3, 0, 40, 0, 0, 1, 1, 40, 0);
    drive(3, 3, 10, 0, 0, 1, 0, 0,  0);
    drive(3, 0, 0,  0, 0, 1, 1, 40, 0);
    idle_cycle();

    // Reset right after an accepted sample discards that result and the state.
    drive(3, 0, 1, 0, 0, 1, 0, 0, 0);
    idle_inputs();
    #1;
    rstn = 1'b0;
    #1;
    chk_reset_outputs("rst_inflight");
    @(posedge clk);
    #1;
    rstn = 1'b1;
    drive(3, 0, 2, 0, 0, 1, 1, 2, 0);

    repeat (3) idle_cycle();
    chk("q4_drained", q4.size(), 0);
    chk("q3_drained", q3.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/feedback_loop_multi.md
# feedback_loop_multi

Parametrised, multi-channel successor to the single-channel signed feedback loop. It keeps one signed state register per channel and, for each accepted sample, computes a saturating accumulate or leaky-integrate update. The channels are time-multiplexed over one input port, and each update is presented one cycle later. It sits between the sample front-end and downstream per-channel consumers in the system1000 clock domain.

## Interface
- `DATA_W`, 8: signed sample, state and output width (≥4).
- `CHANNELS`, 4: number of independent channel states (1..64).
- `CHAN_W`, 2: channel-index width (≥ clog2(CHANNELS), min 1).
- `LEAK_SHIFT`, 2: arithmetic right shift used by leaky mode (1..DATA_W-1).

Ports:
- `system1000` input 1: clock; all state updates on the rising edge.
- `system1000_rstn` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: sample qualifier.
- `in_chan` input CHAN_W: channel index of the sample.
- `in_data` input DATA_W: signed sample x.
- `leak_en` input 1: 0 selects accumulate mode, 1 selects leaky mode. Sampled with `in_valid`.
- `clear` input 1: synchronous clear of all channel states.
- `out_valid` output 1: result qualifier, a one-cycle pulse per accepted sample.
- `out_chan` output CHAN_W: channel of the result.
- `out_data` output DATA_W: signed updated state y.
- `out_sat` output 1: high with `out_valid` when the result was clipped.

## Operation
- **State:** `CHANNELS` × `DATA_W` signed registers, `y[c]`.
- **Sample acceptance:** a sample is accepted when `in_valid`=1 and `in_chan` < `CHANNELS`. Any out-of-range `in_chan` is dropped: no state change and no `out_valid`.
- **Update for an accepted sample on channel c,** computed at DATA_W+2 bits, sign-extended:
  - `p` = 0 if `clear`=1 in the same cycle, else `y[c]`.
  - Accumulate mode: `s` = x + p.
  - Leaky mode: `s` = x + p − (p >>> LEAK_SHIFT), using an arithmetic shift that rounds toward −inf.
  - Result: `y` = `s` clipped to [−2^(DATA_W−1), 2^(DATA_W−1)−1]. `out_sat` = 1 when a clip occurred.
- **Write-back:** `y[c]` ← `y`. The next output for channel c uses the saturated value.
- **Clear:**
  - All `y[*]` are set to 0 at the edge.
  - A sample accepted in the same cycle as `clear` uses p=0, and its result is written to `y[c]`. The write takes priority over the clear for that channel only.
- **Channel independence:** channels never interact. An update to channel c leaves every other channel's state unchanged.
- **Throughput:** one sample per cycle on any channel mix, with no backpressure.
- **Back-to-back samples on the same channel:** the second sample must see the first sample's result. There is no stale read.

## Timing
- **Latency:** sample accepted at edge n gives `out_valid`/`out_chan`/`out_data`/`out_sat` registered at edge n, valid during cycle n+1. The state write happens at the same edge.
- **Output hold:** `out_data`, `out_chan` and `out_sat` hold their last values while `out_valid`=0.
- **`out_sat`:** an unregistered-free pulse, high only in the same cycle as its `out_valid`.
- **Reset values:** asynchronous assertion immediately forces the following values, independent of the clock:
  - `y[*]`=0, `out_valid`=0, `out_chan`=0, `out_data`=0, `out_sat`=0.
- **Reset during operation:** an in-flight result is discarded.
- **Release from reset:** deassertion is synchronous to `system1000` in the surrounding reset synchroniser. The first sample can be accepted at the first edge after deassertion.
- **`clear` without `in_valid`:** zeroes all state at the edge and produces no output.

## Test plan
1. **Reset:** assert `system1000_rstn`=0 mid-cycle while inputs toggle -> all outputs 0 immediately, and they stay 0 while reset is held.
2. **Accumulate, ch0:** `leak_en`=0, x = 10, 20, −5 on consecutive cycles -> `out_data` 10, 30, 25 on the following cycles, `out_chan`=0, `out_sat`=0, `out_valid` for 3 cycles.
3. **Saturation, ch1:** x = 100, 100, −128 -> outputs 100, then 127 with `out_sat`=1, then −1 with `out_sat`=0. Repeat with x = −100, −100 -> outputs −100, then −128 with `out_sat`=1.
4. **Leaky, ch2 (LEAK_SHIFT=2):** x = 64, 0, 0 -> outputs 64, 48, 36. Starting from y = −64, x = 0 -> output −48. Starting from y = −1, x = 0 -> output 0.
5. **Interleaving and clear:**
   - Alternate ch3 x=7 and ch0 x=1 for 4 cycles -> ch3 outputs 7, 14 and ch0 outputs 1, 2.
   - Then `clear`=1 with ch0 x=5 -> output 5. A following ch3 x=1 -> output 1.
6. **Out-of-range channel and reset during operation (CHANNELS=3):**
   - `in_chan`=3 -> no `out_valid` and no state change.
   - Pulse reset after ch0 reaches 40, then ch0 x=2 -> output 2.
